shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 153 +++++++++++++++
 tb/tb_shift_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester arbiter in front of a shared external shifter, with a one-deep result register
// Optional feature macro: SHIFT_ARB_RR_EN (round-robin on contention; fixed priority to requester 0 otherwise)
module shift_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_data,
   input  logic [4:0]       req0_amt,
   input  logic             req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_data,
   input  logic [4:0]       req1_amt,
   input  logic             req1_op,
   output logic [31:0]      sh_data,
   output logic [4:0]       sh_amt,
   output logic             sh_op,
   input  logic [31:0]      sh_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic             rsp_id,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t state;
   state_t state_next;
   logic   slot_free;
   logic   pri0;
   logic   grant0;
   logic   grant1;
   logic   hs;

`ifdef SHIFT_ARB_RR_EN
   logic last;

   // Contention goes to requester 0 whenever requester 1 was the last one served.
   always_comb begin
      pri0 = last;
   end

   // Remember who was served most recently; reset value lets requester 0 win first.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last <= 1'b1;
      end else if (hs) begin
         last <= req1_ready;
      end
   end
`else
   // Fixed priority: requester 0 always wins contention.
   always_comb begin
      pri0 = 1'b1;
   end
`endif

   // Slot accepts a new result when empty, or when the held result drains this cycle.
   always_comb begin
      slot_free = (state == EMPTY) || rsp_ready;
   end

   // Pick at most one valid requester; readies are gated by slot availability and reset.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
         grant0 = pri0;
         grant1 = ~pri0;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
      req0_ready = reset_n & slot_free & grant0;
      req1_ready = reset_n & slot_free & grant1;
      hs         = req0_ready | req1_ready;
   end

   // Shifter operands follow the granted requester, defaulting to requester 0.
   always_comb begin
      if (req1_ready) begin
         sh_data = req1_data;
         sh_amt  = req1_amt;
         sh_op   = req1_op;
      end else begin
         sh_data = req0_data;
         sh_amt  = req0_amt;
         sh_op   = req0_op;
      end
   end

   // Next-state: a handshake always fills the slot; a drain without refill empties it.
   always_comb begin
      state_next = state;
      if (hs) begin
         state_next = FULL;
      end else if ((state == FULL) && rsp_ready) begin
         state_next = EMPTY;
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Result register captures the shifter output on a handshake and holds otherwise.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsp_data <= 32'd0;
         rsp_id   <= 1'b0;
      end else if (hs) begin
         rsp_data <= sh_result;
         rsp_id   <= req1_ready;
      end
   end

   // Saturating per-requester grant counters.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else begin
         if (req0_ready && (gnt_cnt0 != CNT_MAX)) begin
            gnt_cnt0 <= gnt_cnt0 + CNT_ONE;
         end
         if (req1_ready && (gnt_cnt1 != CNT_MAX)) begin
            gnt_cnt1 <= gnt_cnt1 + CNT_ONE;
         end
      end
   end

   // Slot occupancy is the externally visible response valid.
   always_comb begin
      rsp_valid = (state == FULL);
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed self-checking bench for shift_arbiter
module tb_shift_arbiter;

   logic        clock;
   logic        reset_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_data, req1_data;
   logic [4:0]  req0_amt, req1_amt;
   logic        req0_op, req1_op;
   logic [31:0] sh_data, s_sh_data;
   logic [4:0]  sh_amt, s_sh_amt;
   logic        sh_op, s_sh_op;
   logic [31:0] sh_result, s_sh_result;
   logic        rsp_valid, rsp_ready, s_rsp_valid;
   logic [31:0] rsp_data, s_rsp_data;
   logic        rsp_id, s_rsp_id;
   logic [15:0] gnt_cnt0, gnt_cnt1;
   logic        s_req0_ready, s_req1_ready;
   logic [1:0]  s_gnt_cnt0, s_gnt_cnt1;

   int vectors = 0;
   int miscompares = 0;

   function automatic logic [31:0] shifter(input logic [31:0] d, input logic [4:0] a, input logic op);
      if (op) return 32'($signed(d) >>> a);
      else    return d << a;
   endfunction

   assign sh_result   = shifter(sh_data, sh_amt, sh_op);
   assign s_sh_result = shifter(s_sh_data, s_sh_amt, s_sh_op);

   shift_arbiter dut (
      .clock(clock), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
      .req0_amt(req0_amt), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
      .req1_amt(req1_amt), .req1_op(req1_op),
      .sh_data(sh_data), .sh_amt(sh_amt), .sh_op(sh_op), .sh_result(sh_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
   );

   shift_arbiter #(.CNT_W(2)) dut_sat (
      .clock(clock), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_data(req0_data),
      .req0_amt(req0_amt), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_data(req1_data),
      .req1_amt(req1_amt), .req1_op(req1_op),
      .sh_data(s_sh_data), .sh_amt(s_sh_amt), .sh_op(s_sh_op), .sh_result(s_sh_result),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data), .rsp_id(s_rsp_id),
      .gnt_cnt0(s_gnt_cnt0), .gnt_cnt1(s_gnt_cnt1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one rising edge and settle 1 time unit past it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [31:0] exp_data;
      logic        exp_id;
      reset_n = 1'b0;
      req0_valid = 1'b1; req0_data = 32'h0; req0_amt = 5'd0; req0_op = 1'b0;
      req1_valid = 1'b1; req1_data = 32'h0; req1_amt = 5'd0; req1_op = 1'b0;
      rsp_ready = 1'b1;
      step();
      step();
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("rst_cnt0", {16'd0, gnt_cnt0}, 32'd0);
      chk("rst_cnt1", {16'd0, gnt_cnt1}, 32'd0);
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, req1_ready}, 32'd0);

      // single arithmetic right shift from requester 0
      reset_n = 1'b1;
      req1_valid = 1'b0;
      req0_data = 32'h8000_0000; req0_amt = 5'd4; req0_op = 1'b1;
      #1;
      chk("single_ready0", {31'd0, req0_ready}, 32'd1);
      chk("single_ready1", {31'd0, req1_ready}, 32'd0);
      step();
      req0_valid = 1'b0;
      chk("single_valid", {31'd0, rsp_valid}, 32'd1);
      chk("single_data", rsp_data, 32'hF800_0000);
      chk("single_id", {31'd0, rsp_id}, 32'd0);
      chk("single_cnt0", {16'd0, gnt_cnt0}, 32'd1);

      // left shifts from requester 1
      req1_valid = 1'b1; req1_data = 32'h0000_0001; req1_amt = 5'd31; req1_op = 1'b0;
      #1;
      chk("lsl_ready1", {31'd0, req1_ready}, 32'd1);
      step();
      chk("lsl31_data", rsp_data, 32'h8000_0000);
      chk("lsl31_id", {31'd0, rsp_id}, 32'd1);
      req1_data = 32'h1234_ABCD; req1_amt = 5'd0;
      step();
      chk("lsl0_data", rsp_data, 32'h1234_ABCD);
      chk("lsl0_cnt1", {16'd0, gnt_cnt1}, 32'd2);
      req1_valid = 1'b0;
      step();
      chk("drain_empty", {31'd0, rsp_valid}, 32'd0);

      // contention for 4 cycles
      req0_valid = 1'b1; req0_data = 32'h0000_0010; req0_amt = 5'd0; req0_op = 1'b0;
      req1_valid = 1'b1; req1_data = 32'h0000_0020; req1_amt = 5'd0; req1_op = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
`ifdef SHIFT_ARB_RR_EN
         exp_id = (i % 2 == 1);
`else
         exp_id = 1'b0;
`endif
         exp_data = exp_id ? 32'h0000_0020 : 32'h0000_0010;
         chk($sformatf("cont%0d_id", i), {31'd0, rsp_id}, {31'd0, exp_id});
         chk($sformatf("cont%0d_data", i), rsp_data, exp_data);
      end
`ifdef SHIFT_ARB_RR_EN
      chk("cont_cnt0", {16'd0, gnt_cnt0}, 32'd3);
      chk("cont_cnt1", {16'd0, gnt_cnt1}, 32'd4);
`else
      chk("cont_cnt0", {16'd0, gnt_cnt0}, 32'd5);
      chk("cont_cnt1", {16'd0, gnt_cnt1}, 32'd2);
`endif
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();

      // backpressure: fill, hold 3 cycles, then drain and refill together
      req0_valid = 1'b1; req0_data = 32'h0000_0055; req0_amt = 5'd1; req0_op = 1'b0;
      step();
      req0_data = 32'h0000_0003; req0_amt = 5'd2;
      req1_valid = 1'b1;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp%0d_ready0", i), {31'd0, req0_ready}, 32'd0);
         chk($sformatf("bp%0d_ready1", i), {31'd0, req1_ready}, 32'd0);
         chk($sformatf("bp%0d_data", i), rsp_data, 32'h0000_00AA);
         chk($sformatf("bp%0d_id", i), {31'd0, rsp_id}, 32'd0);
         chk($sformatf("bp%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
         step();
      end
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      #1;
      chk("bp_refill_ready0", {31'd0, req0_ready}, 32'd1);
      step();
      chk("bp_refill_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_refill_data", rsp_data, 32'h0000_000C);

      // asynchronous reset while FULL, checked between clock edges
      reset_n = 1'b0;
      #1;
      chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("async_cnt0", {16'd0, gnt_cnt0}, 32'd0);
      chk("async_cnt1", {16'd0, gnt_cnt1}, 32'd0);
      chk("async_data", rsp_data, 32'd0);
      chk("async_ready0", {31'd0, req0_ready}, 32'd0);
      chk("async_sat_cnt0", {30'd0, s_gnt_cnt0}, 32'd0);
      step();

      // saturation: five requester-0 handshakes on the 2-bit counter instance
      reset_n = 1'b1;
      req0_data = 32'h4000_0000; req0_amt = 5'd4; req0_op = 1'b1;
      step();
      chk("sat_cnt_after1", {30'd0, s_gnt_cnt0}, 32'd1);
      for (int i = 0; i < 4; i++) step();
      req0_valid = 1'b0;
      chk("sat_cnt0", {30'd0, s_gnt_cnt0}, 32'd3);
      chk("wide_cnt0", {16'd0, gnt_cnt0}, 32'd5);
      chk("asr_pos_data", rsp_data, 32'h0400_0000);
      step();
      chk("final_empty", {31'd0, rsp_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
